dp_mem_ctrl: RTL and testbench

Parametrised dual-port (one read, one write) synchronous memory.
- Adds reset-driven initialisation, a commanded clear sweep, per-byte write enables, configurable read latency, a read-valid strobe and out-of-range error flags.
- Sits behind the testbench/bus interface as the addressable storage target for read/write interface exercises.
- Generalises the fixed 8x8 memory to arbitrary width/depth.

---
 rtl/dp_mem_pkg.sv | 18 +
 rtl/dp_mem_rd_pipe.sv | 42 ++++
 rtl/dp_mem_ctrl.sv | 104 ++++++++++
 tb/tb_dp_mem_ctrl.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dp_mem_pkg.sv
// Shared types and elaboration helpers for the dp_mem_ctrl memory block.
package dp_mem_pkg;

   typedef enum logic [1:0] {INIT, IDLE, CLEAR} state_t;

   function automatic int be_w(input int data_w);
      return data_w / 8;
   endfunction

   // Legal configuration: byte-multiple width, latency 1 or 2, address wide enough for DEPTH.
   function automatic bit cfg_ok(input int data_w, input int depth, input int addr_w,
                                 input int rd_lat);
      return (data_w > 0) && (data_w % 8 == 0) && (depth > 0) &&
             (rd_lat == 1 || rd_lat == 2) && (addr_w > 0) && (addr_w < 31) &&
             ((1 << addr_w) >= depth);
   endfunction

endpackage

// File: rtl/dp_mem_rd_pipe.sv
// Read return pipeline: RD_LAT stages of {valid, err, data}; the output data holds between strobes.
module dp_mem_rd_pipe #(
   parameter int DATA_W = 8,
   parameter int RD_LAT = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   input  logic              in_err,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   output logic              out_err,
   output logic [DATA_W-1:0] out_data
);

   logic [RD_LAT:1]             vld_pipe;
   logic [RD_LAT:1]             err_pipe;
   logic [RD_LAT:1][DATA_W-1:0] data_pipe;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld_pipe  <= '0;
         err_pipe  <= '0;
         data_pipe <= '0;
      end else begin
         vld_pipe[1] <= in_valid;
         err_pipe[1] <= in_valid & in_err;
         // Only the final stage is qualified, so rd_data keeps its last returned word.
         if (RD_LAT > 1 || in_valid) data_pipe[1] <= in_data;
         for (int i = 2; i <= RD_LAT; i++) begin
            vld_pipe[i] <= vld_pipe[i-1];
            err_pipe[i] <= err_pipe[i-1];
            if (i < RD_LAT || vld_pipe[i-1]) data_pipe[i] <= data_pipe[i-1];
         end
      end
   end

   assign out_valid = vld_pipe[RD_LAT];
   assign out_err   = err_pipe[RD_LAT];
   assign out_data  = data_pipe[RD_LAT];

endmodule

// File: rtl/dp_mem_ctrl.sv
// One-read/one-write synchronous memory with init/clear sweeps, byte enables,
// configurable read latency and out-of-range error reporting.
module dp_mem_ctrl
   import dp_mem_pkg::*;
#(
   parameter int                DATA_W   = 8,
   parameter int                DEPTH    = 8,
   parameter int                ADDR_W   = 3,
   parameter int                RD_LAT   = 1,
   parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  enable,
   input  logic                  rd_en,
   input  logic [ADDR_W-1:0]     rd_addr,
   output logic [DATA_W-1:0]     rd_data,
   output logic                  rd_valid,
   output logic                  rd_err,
   input  logic                  wr_en,
   input  logic [ADDR_W-1:0]     wr_addr,
   input  logic [DATA_W-1:0]     wr_data,
   input  logic [DATA_W/8-1:0]   wr_be,
   output logic                  wr_err,
   input  logic                  clr_req,
   output logic                  busy
);

   localparam int                BE_W    = be_w(DATA_W);
   localparam logic [ADDR_W:0]   DEPTH_X = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);

   if (!cfg_ok(DATA_W, DEPTH, ADDR_W, RD_LAT)) begin : g_bad_cfg
      $error("dp_mem_ctrl: illegal DATA_W/DEPTH/ADDR_W/RD_LAT combination");
   end

   logic [DATA_W-1:0] mem [DEPTH];
   state_t            state;
   logic [ADDR_W-1:0] ptr;
   logic              rd_acc, wr_acc, rd_oob, wr_oob;
   logic [DATA_W-1:0] rd_word;

   // clr_req wins over any same-cycle access; both are dropped silently.
   always_comb begin
      rd_acc  = (state == IDLE) && enable && rd_en && !clr_req;
      wr_acc  = (state == IDLE) && enable && wr_en && !clr_req;
      rd_oob  = {1'b0, rd_addr} >= DEPTH_X;
      wr_oob  = {1'b0, wr_addr} >= DEPTH_X;
      rd_word = rd_oob ? '0 : mem[rd_addr];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= INIT;
         ptr    <= '0;
         busy   <= 1'b1;
         wr_err <= 1'b0;
      end else begin
         wr_err <= wr_acc && wr_oob;
         case (state)
            INIT, CLEAR: begin
               ptr <= ptr + ADDR_W'(1);
               if (ptr == LAST) begin
                  state <= IDLE;
                  busy  <= 1'b0;
                  ptr   <= '0;
               end
            end
            default: begin
               if (clr_req) begin
                  state <= CLEAR;
                  ptr   <= '0;
                  busy  <= 1'b1;
               end
            end
         endcase
      end
   end

   // Storage is never reset; the sweep rewrites it. Reads sample before this edge's write.
   always_ff @(posedge clk) begin
      if (state != IDLE) begin
         mem[ptr] <= INIT_VAL;
      end else if (wr_acc && !wr_oob) begin
         for (int i = 0; i < BE_W; i++)
            if (wr_be[i]) mem[wr_addr][8*i +: 8] <= wr_data[8*i +: 8];
      end
   end

   dp_mem_rd_pipe #(
      .DATA_W (DATA_W),
      .RD_LAT (RD_LAT)
   ) u_rd_pipe (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (rd_acc),
      .in_err    (rd_oob),
      .in_data   (rd_word),
      .out_valid (rd_valid),
      .out_err   (rd_err),
      .out_data  (rd_data)
   );

endmodule

// File: tb/tb_dp_mem_ctrl.sv
// Directed bench for dp_mem_ctrl (16-bit, 6 words, 2-cycle reads) against a queue-based model.
module tb_dp_mem_ctrl;

   localparam int             DW  = 16;
   localparam int             DEP = 6;
   localparam int             AW  = 3;
   localparam int             LAT = 2;
   localparam int             BW  = DW / 8;
   localparam logic [DW-1:0]  IV  = 16'h5A3C;

   logic          clk = 1'b0, rst = 1'b1;
   logic          enable = 1'b0, rd_en = 1'b0, wr_en = 1'b0, clr_req = 1'b0;
   logic [AW-1:0] rd_addr = '0, wr_addr = '0;
   logic [DW-1:0] wr_data = '0;
   logic [BW-1:0] wr_be = '0;
   logic [DW-1:0] rd_data;
   logic          rd_valid, rd_err, wr_err, busy;

   int n_cmp = 0, n_fail = 0;

   always #5 clk = ~clk;

   dp_mem_ctrl #(
      .DATA_W (DW), .DEPTH (DEP), .ADDR_W (AW), .RD_LAT (LAT), .INIT_VAL (IV)
   ) dut (
      .clk (clk), .rst (rst), .enable (enable),
      .rd_en (rd_en), .rd_addr (rd_addr), .rd_data (rd_data),
      .rd_valid (rd_valid), .rd_err (rd_err),
      .wr_en (wr_en), .wr_addr (wr_addr), .wr_data (wr_data), .wr_be (wr_be),
      .wr_err (wr_err), .clr_req (clr_req), .busy (busy)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   // Model: sweep countdown, word array, and a queue of read results due at a given cycle.
   typedef struct {
      int            due;
      logic [DW-1:0] data;
      logic          err;
   } rd_t;

   logic [DW-1:0] m_mem [DEP];
   rd_t           rq[$];
   rd_t           m_r;
   int            busy_cnt, cyc;
   logic [DW-1:0] e_data;
   logic          e_valid, e_err, e_wr_err;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         busy_cnt = DEP;
         cyc      = 0;
         rq.delete();
         e_data   = '0;
         e_valid  = 1'b0;
         e_err    = 1'b0;
         e_wr_err = 1'b0;
      end else begin
         cyc++;
         e_valid  = 1'b0;
         e_err    = 1'b0;
         e_wr_err = 1'b0;
         if (busy_cnt > 0) begin
            m_mem[DEP - busy_cnt] = IV;
            busy_cnt--;
         end else if (clr_req) begin
            busy_cnt = DEP;
         end else if (enable) begin
            if (rd_en) begin
               m_r.due  = cyc + LAT - 1;
               m_r.err  = int'(rd_addr) >= DEP;
               m_r.data = m_r.err ? '0 : m_mem[rd_addr];
               rq.push_back(m_r);
            end
            if (wr_en) begin
               if (int'(wr_addr) >= DEP) e_wr_err = 1'b1;
               else
                  for (int i = 0; i < BW; i++)
                     if (wr_be[i]) m_mem[wr_addr][8*i +: 8] = wr_data[8*i +: 8];
            end
         end
         if (rq.size() > 0 && rq[0].due == cyc) begin
            e_valid = 1'b1;
            e_err   = rq[0].err;
            e_data  = rq[0].data;
            void'(rq.pop_front());
         end
      end
   end

   always @(negedge clk) begin
      chk("busy",     busy,     busy_cnt > 0);
      chk("rd_valid", rd_valid, e_valid);
      chk("rd_err",   rd_err,   e_err);
      chk("rd_data",  rd_data,  e_data);
      chk("wr_err",   wr_err,   e_wr_err);
   end

   // Each call starts and ends 1 time unit after a rising edge.
   task automatic drive(input logic r, input logic [AW-1:0] ra, input logic w,
                        input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                        input logic [BW-1:0] be, input logic c);
      enable = 1'b1; rd_en = r; rd_addr = ra;
      wr_en = w; wr_addr = wa; wr_data = wd; wr_be = be; clr_req = c;
      @(posedge clk); #1;
      rd_en = 1'b0; wr_en = 1'b0; clr_req = 1'b0;
   endtask

   task automatic rd(input logic [AW-1:0] a);
      drive(1'b1, a, 1'b0, '0, '0, '0, 1'b0);
   endtask

   task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [BW-1:0] be);
      drive(1'b0, '0, 1'b1, a, d, be, 1'b0);
   endtask

   task automatic expect_read(input string name, input logic [DW-1:0] d, input logic e);
      bit got = 0;
      for (int k = 0; k < 10 && !got; k++) begin
         @(negedge clk);
         if (rd_valid) begin
            chk(name, rd_data, d);
            chk({name, "_err"}, rd_err, e);
            got = 1;
         end
      end
      if (!got) chk({name, "_timeout"}, 32'd0, 32'd1);
      @(posedge clk); #1;
   endtask

   task automatic wait_idle(input string name, input int exp_cycles);
      int n = 0;
      @(negedge clk);
      while (busy && n < 50) begin
         n++;
         @(negedge clk);
      end
      chk(name, n, exp_cycles);
      @(posedge clk); #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: bench did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_busy", busy, 1'b1);
      chk("rst_rd_valid", rd_valid, 1'b0);
      chk("rst_rd_data", rd_data, 16'h0000);
      @(posedge clk); #1;
      rst = 1'b0;
      wait_idle("init_busy_cycles", DEP);

      for (int a = 0; a < DEP; a++) begin
         rd(AW'(a));
         expect_read("init_word", IV, 1'b0);
      end

      wr(3'd3, 16'h00A5, 2'b11);
      rd(3'd3);
      expect_read("rd_after_wr", 16'h00A5, 1'b0);

      wr(3'd2, 16'h1234, 2'b11);
      wr(3'd2, 16'hFFFF, 2'b01);
      rd(3'd2);
      expect_read("byte_enable", 16'h12FF, 1'b0);

      wr(3'd5, 16'h003B, 2'b11);
      drive(1'b1, 3'd5, 1'b1, 3'd5, 16'h0077, 2'b11, 1'b0);
      expect_read("read_first_old", 16'h003B, 1'b0);
      rd(3'd5);
      expect_read("read_first_new", 16'h0077, 1'b0);

      rd(3'd7);
      expect_read("oob_read7", 16'h0000, 1'b1);
      rd(3'd6);
      expect_read("oob_read6", 16'h0000, 1'b1);
      wr(3'd6, 16'hABCD, 2'b11);
      @(negedge clk); chk("wr_err_pulse", wr_err, 1'b1);
      @(negedge clk); chk("wr_err_drop", wr_err, 1'b0);
      @(posedge clk); #1;
      rd(3'd0);
      expect_read("oob_wr_no_alias", IV, 1'b0);

      wr(3'd2, 16'h0000, 2'b00);
      rd(3'd2);
      expect_read("be_zero", 16'h12FF, 1'b0);

      rd(3'd2); rd(3'd3); rd(3'd5); rd(3'd7);
      repeat (4) @(posedge clk);
      #1;

      enable = 1'b0; rd_en = 1'b1; rd_addr = 3'd4;
      wr_en = 1'b1; wr_addr = 3'd4; wr_data = 16'hDEAD; wr_be = 2'b11;
      @(posedge clk); #1;
      rd_en = 1'b0; wr_en = 1'b0;
      rd(3'd4);
      expect_read("enable_low", IV, 1'b0);

      drive(1'b1, 3'd3, 1'b1, 3'd0, 16'hBEEF, 2'b11, 1'b1);
      drive(1'b1, 3'd2, 1'b1, 3'd1, 16'h1111, 2'b11, 1'b1);
      wait_idle("clear_busy_cycles", DEP - 1);
      for (int a = 0; a < DEP; a++) begin
         rd(AW'(a));
         expect_read("after_clear", IV, 1'b0);
      end

      wr(3'd2, 16'hC0DE, 2'b11);
      rd(3'd2);
      drive(1'b0, '0, 1'b0, '0, '0, '0, 1'b1);
      expect_read("read_spans_clear", 16'hC0DE, 1'b0);
      @(posedge clk); #1;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      wait_idle("reinit_after_clear_rst", DEP);

      wr(3'd3, 16'h4242, 2'b11);
      rd(3'd3);
      rst = 1'b1;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         chk("abort_no_valid", rd_valid, 1'b0);
      end
      @(posedge clk); #1;
      rst = 1'b0;
      wait_idle("reinit_after_abort", DEP);
      for (int a = 0; a < DEP; a++) begin
         rd(AW'(a));
         expect_read("after_reinit", IV, 1'b0);
      end

      repeat (3) @(posedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
